// File: rtl/load_store_unit.sv
// Load/store sequencer between the RV32I core and a word-wide data memory.
// Optional misalignment trapping: define LSU_MISALIGN_TRAP_EN.
module load_store_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] ldata_q, ldata_d;

    logic        f3_bad;
    logic        misalign;
    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] wdata_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign f3_bad = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                    (funct3 == 3'b111) || (is_store && funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = f3_bad || misalign;

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            sdata_q  <= '0;
            merge_q  <= '0;
            ldata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            sdata_q  <= sdata_d;
            merge_q  <= merge_d;
            ldata_q  <= ldata_d;
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        sdata_d  = sdata_q;
        merge_d  = merge_q;
        ldata_d  = ldata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = addr;
                    funct3_d = funct3;
                    store_d  = is_store;
                    sdata_d  = store_data;
                    if (req_err)
                        state_d = S_ERR;
                    else if (!is_store)
                        state_d = S_RD;
                    else if (funct3 == 3'b010)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (store_q) begin
                    merge_d = mem_rdata;
                    state_d = S_WR;
                end else begin
                    ldata_d = load_ext;
                    state_d = S_DONE;
                end
            end
            S_WR:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = mem_rdata;
        unique case (funct3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h0, lane_b};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    // Sub-word stores patch the word captured during RD
    always_comb begin
        wdata_c = merge_q;
        unique case (funct3_q[1:0])
            2'b00:   wdata_c[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
            2'b01:   wdata_c[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
            default: wdata_c = sdata_q;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        mem_read  = (state_q == S_RD);
        mem_write = (state_q == S_WR);
        done      = (state_q == S_DONE) || (state_q == S_ERR);
        err       = (state_q == S_ERR);
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_c;
    assign load_data = ldata_q;

endmodule
